// File: rtl/rx_bit_timer.sv
// rx_bit_timer: bit-timing controller for the serial receive path.
// Divides the clock into CLKS_PER_BIT-cycle bit periods, strobes shift_enable
// once per bit at phase SAMPLE_POINT, and pulses packet_done after
// BITS_PER_PKT bits.
// Optional macro RX_TIMER_RESYNC_EN: when defined, a resync pulse during
// COUNT realigns the bit phase; when undefined, resync is ignored.
module rx_bit_timer #(
   parameter int CLKS_PER_BIT = 8,
   parameter int SAMPLE_POINT = 3,
   parameter int BITS_PER_PKT = 8
) (
   input  logic                            clk,
   input  logic                            n_rst,
   input  logic                            enable_timer,
   input  logic                            resync,
   output logic                            shift_enable,
   output logic                            packet_done,
   output logic [$clog2(BITS_PER_PKT)-1:0] bit_index,
   output logic                            timer_active
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(BITS_PER_PKT);

   localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] SAMPLE   = CW'(SAMPLE_POINT);
   localparam logic [BW-1:0] BIT_LAST = BW'(BITS_PER_PKT - 1);

   typedef enum logic [1:0] {
      IDLE,
      COUNT,
      DONE
   } state_t;

   state_t        state, state_nx;
   logic [CW-1:0] clk_cnt, clk_nx;
   logic [BW-1:0] bit_cnt, bit_nx;

`ifndef RX_TIMER_RESYNC_EN
   logic unused_resync;
   assign unused_resync = resync;
`endif

   // State and counter registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state   <= IDLE;
         clk_cnt <= '0;
         bit_cnt <= '0;
      end else begin
         state   <= state_nx;
         clk_cnt <= clk_nx;
         bit_cnt <= bit_nx;
      end
   end

   // Next-state and counter update; abort (enable low) wins over everything.
   always_comb begin
      state_nx = state;
      clk_nx   = clk_cnt;
      bit_nx   = bit_cnt;
      case (state)
         IDLE: begin
            clk_nx = '0;
            bit_nx = '0;
            if (enable_timer) state_nx = COUNT;
         end
         COUNT: begin
            if (!enable_timer) begin
               state_nx = IDLE;
               clk_nx   = '0;
               bit_nx   = '0;
            end
`ifdef RX_TIMER_RESYNC_EN
            else if (resync) begin
               // The resync cycle counts as phase 0, so the next phase is 1.
               if (clk_cnt <= SAMPLE) begin
                  clk_nx = CW'(1);
               end else if (bit_cnt == BIT_LAST) begin
                  // DONE restarts from zero counters regardless of phase.
                  state_nx = DONE;
                  clk_nx   = '0;
                  bit_nx   = '0;
               end else begin
                  clk_nx = CW'(1);
                  bit_nx = bit_cnt + BW'(1);
               end
            end
`endif
            else if (clk_cnt == CLK_LAST) begin
               if (bit_cnt == BIT_LAST) begin
                  state_nx = DONE;
                  clk_nx   = '0;
                  bit_nx   = '0;
               end else begin
                  clk_nx = '0;
                  bit_nx = bit_cnt + BW'(1);
               end
            end else begin
               clk_nx = clk_cnt + CW'(1);
            end
         end
         DONE: begin
            clk_nx   = '0;
            bit_nx   = '0;
            state_nx = enable_timer ? COUNT : IDLE;
         end
         default: begin
            state_nx = IDLE;
            clk_nx   = '0;
            bit_nx   = '0;
         end
      endcase
   end

   // Outputs decoded purely from registered state and counters.
   always_comb begin
      shift_enable = (state == COUNT) && (clk_cnt == SAMPLE);
      packet_done  = (state == DONE);
      timer_active = (state == COUNT);
      bit_index    = bit_cnt;
   end

endmodule
